// File: rtl/ccl_pkg.sv
// Shared definitions for the CCL result-buffer drain controller.
// Build option: CCL_RD_HDR_EN adds a 0xA5 header byte ahead of the drain stream.
package ccl_pkg;

  localparam int unsigned CCL_MAX_LEN  = 4;
  localparam int unsigned CCL_POS_LAST = 9;
  localparam logic [7:0]  CCL_HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_READ = 3'd2,
    ST_WAIT = 3'd3,
    ST_SEND = 3'd4,
    ST_FIN  = 3'd5
  } ccl_state_e;

endpackage

// File: rtl/ccl_idx_cnt.sv
// Nested (len, pos) index counter for the drain walk: pos is the inner index,
// len the outer one. clr reloads (1, 0) and takes priority over adv.
module ccl_idx_cnt
  import ccl_pkg::*;
#(
  parameter int unsigned MAX_LEN  = CCL_MAX_LEN,
  parameter int unsigned POS_LAST = CCL_POS_LAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [2:0] len,
  output logic [3:0] pos,
  output logic       is_last
);

  localparam logic [2:0] LEN_TOP = 3'(MAX_LEN);
  localparam logic [3:0] POS_TOP = 4'(POS_LAST);

  logic [2:0] len_q, len_d;
  logic [3:0] pos_q, pos_d;

  // Next index: pos wraps into a len increment; len saturates at its top.
  always_comb begin
    len_d = len_q;
    pos_d = pos_q;
    if (clr) begin
      len_d = 3'd1;
      pos_d = '0;
    end else if (adv) begin
      if (pos_q == POS_TOP) begin
        pos_d = '0;
        if (len_q != LEN_TOP) len_d = len_q + 3'd1;
      end else begin
        pos_d = pos_q + 4'd1;
      end
    end
  end

  // Index registers with synchronous reset to the first entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= 3'd1;
      pos_q <= '0;
    end else begin
      len_q <= len_d;
      pos_q <= pos_d;
    end
  end

  assign len     = len_q;
  assign pos     = pos_q;
  assign is_last = (len_q == LEN_TOP) && (pos_q == POS_TOP);

endmodule

// File: rtl/ccl_rd_ctr.sv
// Drain-side controller for the CCL result buffer. Walks every (len, pos)
// entry in scan order, issues one read per entry, captures the returned byte
// and streams it out over valid/ready. Three cycles per byte at full rate.
// Build option: CCL_RD_HDR_EN inserts a 0xA5 header byte before the entries.
module ccl_rd_ctr
  import ccl_pkg::*;
#(
  parameter int unsigned MAX_LEN  = CCL_MAX_LEN,
  parameter int unsigned POS_LAST = CCL_POS_LAST,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [2:0]        rd_len,
  output logic [3:0]        rd_pos,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  ccl_state_e        state_q;
  logic              rd_en_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;

  logic              cnt_clr;
  logic              cnt_adv;
  logic              cnt_last;
  logic              hs;

  assign hs = out_valid_q && out_ready;

  ccl_idx_cnt #(
    .MAX_LEN  (MAX_LEN),
    .POS_LAST (POS_LAST)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .adv     (cnt_adv),
    .len     (rd_len),
    .pos     (rd_pos),
    .is_last (cnt_last)
  );

  // Counter control: step after each non-final handshake, reload on FIN or
  // on any encoding the FSM does not recognise.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    case (state_q)
      ST_IDLE, ST_READ, ST_WAIT: ;
`ifdef CCL_RD_HDR_EN
      ST_HDR: ;
`endif
      ST_SEND: cnt_adv = hs && !cnt_last;
      ST_FIN:  cnt_clr = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
  end

  // Drain FSM; every output is a register set on the transition into the
  // state where it must be visible (rd_en in READ, done in FIN).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
`ifdef CCL_RD_HDR_EN
            state_q     <= ST_HDR;
            out_valid_q <= 1'b1;
            out_data_q  <= DATA_W'(CCL_HDR_BYTE);
            out_last_q  <= 1'b0;
`else
            state_q <= ST_READ;
            rd_en_q <= 1'b1;
`endif
          end
        end
`ifdef CCL_RD_HDR_EN
        ST_HDR: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_READ;
            rd_en_q     <= 1'b1;
          end
        end
`endif
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: begin
          out_data_q  <= rd_data;
          out_last_q  <= cnt_last;
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (cnt_last) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          out_last_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ccl_rd_ctr.sv
// Self-checking bench for ccl_rd_ctr: a stream-level model predicts the read
// address sequence, the byte stream, handshake stability and drain timing.
module tb_ccl_rd_ctr;

`ifdef CCL_RD_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NPOS = 10;
  localparam int NLEN = 4;
  localparam int NB   = NLEN * NPOS + HDR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rd_en;
  logic [2:0] rd_len;
  logic [3:0] rd_pos;
  logic [7:0] rd_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ccl_rd_ctr #(
    .MAX_LEN  (4),
    .POS_LAST (9),
    .DATA_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rd_en     (rd_en),
    .rd_len    (rd_len),
    .rd_pos    (rd_pos),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Result buffer: entry {len,pos} exactly one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (rd_en) rd_data <= {1'b0, rd_len, rd_pos};
    else       rd_data <= 8'($urandom);
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    int j;
    if (HDR == 1 && i == 0) return 8'hA5;
    j = i - HDR;
    return 8'((1 + j / NPOS) * 16 + j % NPOS);
  endfunction

  // Model state, written only by the monitor.
  bit         inited      = 0;
  bit         rst_was_low = 0;
  bit         active      = 0;
  bit         was_active  = 0;
  bit         fin_next    = 0;
  bit         all_ready   = 0;
  bit         hold_v      = 0;
  logic [7:0] hold_d      = 8'h00;
  bit         hold_l      = 0;
  int         cyc         = 0;
  int         hs_idx      = 0;
  int         rd_idx      = 0;
  int         done_cnt    = 0;
  int         to_seen     = 0;
  int         to_req      = 0;   // bumped by stimulus on an expired wait bound

  always @(negedge clk) begin
    if (to_req != to_seen) begin
      chk("wait_bound", 32'(to_req), 32'(to_seen));
      to_seen = to_req;
    end
    if (rst_was_low) begin
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rd_en",     32'(rd_en),     32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_rd_len",    32'(rd_len),    32'd1);
      chk("rst_rd_pos",    32'(rd_pos),    32'd0);
    end else if (inited && rst_n) begin
      was_active = active;
      if (active) cyc++;
      chk("done", 32'(done), 32'(fin_next));
      chk("busy", 32'(busy), 32'(active));
      if (!active) begin
        chk("idle_rd_en",     32'(rd_en),     32'd0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_rd_len",    32'(rd_len),    32'd1);
        chk("idle_rd_pos",    32'(rd_pos),    32'd0);
      end
      if (fin_next) begin
        chk("drain_handshakes", 32'(hs_idx), 32'(NB));
        if (all_ready) chk("drain_cycles", 32'(cyc), 32'(121 + HDR));
        done_cnt++;
        active   = 0;
        fin_next = 0;
      end
      if (hold_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  32'(out_data),  32'(hold_d));
        chk("hold_last",  32'(out_last),  32'(hold_l));
      end
      if (rd_en) begin
        chk("rd_len", 32'(rd_len), 32'(1 + rd_idx / NPOS));
        chk("rd_pos", 32'(rd_pos), 32'(rd_idx % NPOS));
        rd_idx++;
      end
      if (out_valid && out_ready) begin
        chk("out_data", 32'(out_data), 32'(exp_byte(hs_idx)));
        chk("out_last", 32'(out_last), 32'(hs_idx == NB - 1));
        if (hs_idx == 0) chk("first_byte", 32'(out_data), (HDR == 1) ? 32'hA5 : 32'h10);
        if (out_last)    chk("last_byte",  32'(out_data), 32'h49);
        hs_idx++;
        if (hs_idx == NB) fin_next = 1;
      end
      if (out_valid && !out_ready) all_ready = 0;
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (!was_active && start) begin
        active    = 1;
        cyc       = 0;
        hs_idx    = 0;
        rd_idx    = 0;
        all_ready = 1;
      end
    end
    if (!rst_n) begin
      inited   = 1;
      active   = 0;
      fin_next = 0;
      hold_v   = 0;
    end
    rst_was_low = !rst_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int target;
    int n;
    target = done_cnt + 1;
    n = 0;
    while (done_cnt < target && n < budget) begin
      out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      step();
      n++;
    end
    if (done_cnt < target) to_req++;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (!(hs_idx >= target && out_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) to_req++;
  endtask

  task automatic run_drain(input bit rnd, input int budget);
    start = 1'b1;
    out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    step();
    start = 1'b0;
    wait_done(budget, rnd);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) step();

    // Full-rate drain.
    run_drain(1'b0, 300);
    repeat (4) step();

    // Random backpressure, ready asserted ~30% of cycles.
    run_drain(1'b1, 3000);
    repeat (4) step();

    // start pulsed mid-drain must be ignored.
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_hs(15, 200);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(300, 1'b0);
    repeat (10) step();

    // Reset during SEND of byte 22, then a clean restart.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_hs(21, 200);
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    run_drain(1'b1, 3000);
    repeat (4) step();

    // start held through FIN chains straight into a second drain.
    start = 1'b1;
    wait_done(300, 1'b0);
    step();
    step();
    start = 1'b0;
    wait_done(300, 1'b0);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
